// File: rtl/rab_lookup_arb_if.sv
// Bundles the AR/AW request channels, the slice-lookup port and the result
// handshake of the remapping-unit lookup arbiter.
interface rab_lookup_arb_if #(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 4
);
  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_WIDTH_VIRT-1:0] ar_addr;
  logic [7:0]                 ar_len;
  logic [2:0]                 ar_size;
  logic [ID_WIDTH-1:0]        ar_id;

  logic                       aw_valid;
  logic                       aw_ready;
  logic [ADDR_WIDTH_VIRT-1:0] aw_addr;
  logic [7:0]                 aw_len;
  logic [2:0]                 aw_size;
  logic [ID_WIDTH-1:0]        aw_id;

  logic                       lu_rw;
  logic [ADDR_WIDTH_VIRT-1:0] lu_addr_min;
  logic [ADDR_WIDTH_VIRT-1:0] lu_addr_max;
  logic [N_SLICES-1:0]        lu_hit;
  logic [N_SLICES-1:0]        lu_prot;
  logic                       lu_multiple_hit;
  logic                       lu_master_select;
  logic [ADDR_WIDTH_PHYS-1:0] lu_out_addr;

  logic                       res_valid;
  logic                       res_ready;
  logic                       res_rw;
  logic [ID_WIDTH-1:0]        res_id;
  logic [ADDR_WIDTH_PHYS-1:0] res_addr;
  logic                       res_master_select;
  logic [1:0]                 res_err;

  // Arbiter side: consumes requests and lookup results, produces results.
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_id,
    input  aw_valid, aw_addr, aw_len, aw_size, aw_id,
    input  lu_hit, lu_prot, lu_multiple_hit, lu_master_select, lu_out_addr,
    input  res_ready,
    output ar_ready, aw_ready,
    output lu_rw, lu_addr_min, lu_addr_max,
    output res_valid, res_rw, res_id, res_addr, res_master_select, res_err
  );

  // Environment side: address channels, lookup array and result consumer.
  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_id,
    output aw_valid, aw_addr, aw_len, aw_size, aw_id,
    output lu_hit, lu_prot, lu_multiple_hit, lu_master_select, lu_out_addr,
    output res_ready,
    input  ar_ready, aw_ready,
    input  lu_rw, lu_addr_min, lu_addr_max,
    input  res_valid, res_rw, res_id, res_addr, res_master_select, res_err
  );
endinterface

// File: rtl/rab_lookup_arb.sv
// Round-robin AR/AW arbiter in front of the shared slice-lookup datapath:
// accept, look up for one cycle, then hold the classified result until consumed.
module rab_lookup_arb #(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 4
) (
  input logic              axi4_aclk,
  input logic              axi4_arstn,
  rab_lookup_arb_if.slave  bus
);
  localparam int EXT_W = ADDR_WIDTH_VIRT + 12;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_MISS  = 2'd1;
  localparam logic [1:0] ERR_PROT  = 2'd2;
  localparam logic [1:0] ERR_MULTI = 2'd3;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t state, state_nxt;
  logic   rr_last;   // 0 = AR, 1 = AW

  logic                       grant_vld, grant_aw, idle_ok, hs;
  logic [ADDR_WIDTH_VIRT-1:0] sel_addr;
  logic [7:0]                 sel_len;
  logic [2:0]                 sel_size;
  logic [ID_WIDTH-1:0]        sel_id;
  logic [ADDR_WIDTH_VIRT:0]   sel_range;
  logic [N_SLICES-1:0]        hit_vec, prot_vec;
  logic [1:0]                 lu_err;

  logic                       req_rw_p0, req_ovf_p0;
  logic [ID_WIDTH-1:0]        req_id_p0;
  logic [ADDR_WIDTH_VIRT-1:0] req_min_p0, req_max_p0;

  logic [ADDR_WIDTH_PHYS-1:0] res_addr_p1;
  logic                       res_ms_p1;
  logic [1:0]                 res_err_p1;

  // Returns {overflow, inclusive end address}; the span needs at most 16 bits.
  function automatic logic [ADDR_WIDTH_VIRT:0] calc_range(
    input logic [ADDR_WIDTH_VIRT-1:0] addr,
    input logic [7:0]                 len,
    input logic [2:0]                 size
  );
    logic [EXT_W-1:0] span;
    logic [EXT_W-1:0] last;
    span = (EXT_W'(len) + EXT_W'(1)) << size;
    last = EXT_W'(addr) + span - EXT_W'(1);
    return {|last[EXT_W-1:ADDR_WIDTH_VIRT], last[ADDR_WIDTH_VIRT-1:0]};
  endfunction

  function automatic logic [1:0] classify(
    input logic ovf, input logic multi, input logic any_hit, input logic any_prot
  );
    if (ovf)           return ERR_MISS;
    else if (multi)    return ERR_MULTI;
    else if (any_hit)  return ERR_OK;
    else if (any_prot) return ERR_PROT;
    else               return ERR_MISS;
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_aw  = 1'b0;
    if (bus.ar_valid && bus.aw_valid) begin
      grant_vld = 1'b1;
      grant_aw  = ~rr_last;
    end else if (bus.ar_valid) begin
      grant_vld = 1'b1;
    end else if (bus.aw_valid) begin
      grant_vld = 1'b1;
      grant_aw  = 1'b1;
    end
  end

  // Ready is gated by reset so nothing looks accepted while held in reset.
  assign idle_ok      = (state == IDLE) && axi4_arstn;
  assign hs           = idle_ok && grant_vld;
  assign bus.ar_ready = hs && !grant_aw;
  assign bus.aw_ready = hs && grant_aw;

  assign sel_addr  = grant_aw ? bus.aw_addr : bus.ar_addr;
  assign sel_len   = grant_aw ? bus.aw_len  : bus.ar_len;
  assign sel_size  = grant_aw ? bus.aw_size : bus.ar_size;
  assign sel_id    = grant_aw ? bus.aw_id   : bus.ar_id;
  assign sel_range = calc_range(sel_addr, sel_len, sel_size);

  assign hit_vec  = bus.lu_hit;
  assign prot_vec = bus.lu_prot;
  assign lu_err   = classify(req_ovf_p0, bus.lu_multiple_hit, |hit_vec, |prot_vec);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) state <= IDLE;
    else             state <= state_nxt;
  end

  // p0: request register, captured at acceptance
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      rr_last    <= 1'b1;
      req_rw_p0  <= 1'b0;
      req_ovf_p0 <= 1'b0;
      req_id_p0  <= '0;
      req_min_p0 <= '0;
      req_max_p0 <= '0;
    end else if (hs) begin
      rr_last    <= grant_aw;
      req_rw_p0  <= grant_aw;
      req_ovf_p0 <= sel_range[ADDR_WIDTH_VIRT];
      req_id_p0  <= sel_id;
      req_min_p0 <= sel_addr;
      req_max_p0 <= sel_range[ADDR_WIDTH_VIRT-1:0];
    end
  end

  // p1: lookup result, sampled at the end of the LOOKUP cycle
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      res_addr_p1 <= '0;
      res_ms_p1   <= 1'b0;
      res_err_p1  <= ERR_OK;
    end else if (state == LOOKUP) begin
      res_err_p1  <= lu_err;
      res_addr_p1 <= (lu_err == ERR_OK) ? bus.lu_out_addr : '0;
      res_ms_p1   <= (lu_err == ERR_OK) ? bus.lu_master_select : 1'b0;
    end
  end

  assign bus.lu_rw       = req_rw_p0;
  assign bus.lu_addr_min = req_min_p0;
  assign bus.lu_addr_max = req_max_p0;

  assign bus.res_valid         = (state == RESP);
  assign bus.res_rw            = req_rw_p0;
  assign bus.res_id            = req_id_p0;
  assign bus.res_addr          = res_addr_p1;
  assign bus.res_master_select = res_ms_p1;
  assign bus.res_err           = res_err_p1;
endmodule
